// File: rtl/shift_pkg.sv
// Shared constants and helpers for the word serializer feeding the bidirectional shift register.
package shift_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    // Left shift sends MSB first, right shift sends LSB first, so the word lands unrotated downstream.
    function automatic int unsigned bit_idx(input int unsigned width, input int unsigned cnt,
                                            input logic dir);
        return (dir == DIR_RIGHT) ? cnt : (width - 1 - cnt);
    endfunction

endpackage

// File: rtl/shift_word_serializer.sv
// Serializes a handshaken parallel word into d/en/dir for a bidirectional shift register.
module shift_word_serializer
    import shift_pkg::*;
#(
    parameter int MSB = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [MSB-1:0] in_data,
    input  logic           in_dir,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           d,
    output logic           en,
    output logic           dir,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(MSB);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [MSB-1:0] shadow_q, shadow_d;
    logic           dir_q, dir_d;
    logic           d_q, d_d;
    logic           en_q, en_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    assign in_ready = (state_q == IDLE);
    assign d        = d_q;
    assign en       = en_q;
    assign dir      = dir_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Outputs are computed one cycle ahead so every frame signal leaves straight from a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        dir_d    = dir_q;
        d_d      = 1'b0;
        en_d     = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (in_valid) begin
                    shadow_d = in_data;
                    dir_d    = in_dir;
                    state_d  = SHIFT;
                    en_d     = 1'b1;
                    busy_d   = 1'b1;
                    d_d      = in_data[CW'(bit_idx(MSB, 0, in_dir))];
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (cnt_q == CW'(MSB - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    en_d  = 1'b1;
                    d_d   = shadow_q[CW'(bit_idx(MSB, 32'(cnt_d), dir_q))];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            dir_q    <= 1'b0;
            d_q      <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            dir_q    <= dir_d;
            d_q      <= d_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_shift_word_serializer.sv
// Bench for shift_word_serializer: frames are rebuilt in a model of the downstream shift register.
module tb_shift_word_serializer;

    localparam int MSB = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [MSB-1:0] in_data;
    logic           in_dir;
    logic           in_valid;
    logic           in_ready;
    logic           d, en, dir, busy, done;
    logic [MSB-1:0] ds;

    int errors = 0;
    int checks = 0;

    shift_word_serializer #(.MSB(MSB)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dir(in_dir), .in_valid(in_valid),
        .in_ready(in_ready), .d(d), .en(en), .dir(dir), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Downstream bidirectional shift register: left shifts in at bit 0, right shifts in at the top.
    always @(posedge clk) begin
        if (en) ds <= dir ? {d, ds[MSB-1:1]} : {ds[MSB-2:0], d};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({d, en, dir, busy, done, in_ready} !== 6'b000001) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got d,en,dir,busy,done,rdy=%b exp=000001", i,
                         {d, en, dir, busy, done, in_ready});
            end
            tick();
        end
    endtask

    task automatic run_frame(input logic [MSB-1:0] w, input logic wd);
        logic exp_bit;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame_ready got=%b exp=1", in_ready);
        end
        in_data = w; in_dir = wd; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < MSB; i++) begin
            exp_bit = wd ? w[i] : w[MSB-1-i];
            checks++;
            if ({en, d, dir, busy, done, in_ready} !== {1'b1, exp_bit, wd, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL frame_bit w=%h dir=%b i=%0d got en,d,dir,busy,done,rdy=%b exp=%b",
                         w, wd, i, {en, d, dir, busy, done, in_ready},
                         {1'b1, exp_bit, wd, 1'b1, 1'b0, 1'b0});
            end
            in_data = MSB'($urandom); in_dir = ~wd;
            tick();
        end
        checks++;
        if ({en, d, dir, busy, done, in_ready} !== {1'b0, 1'b0, wd, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL frame_done w=%h got en,d,dir,busy,done,rdy=%b exp=%b", w,
                     {en, d, dir, busy, done, in_ready}, {1'b0, 1'b0, wd, 1'b1, 1'b1, 1'b0});
        end
        checks++;
        if (ds !== w) begin
            errors++;
            $display("FAIL frame_downstream got=%h exp=%h dir=%b", ds, w, wd);
        end
        tick();
        checks++;
        if ({en, busy, done, in_ready, dir} !== {4'b0001, wd}) begin
            errors++;
            $display("FAIL frame_idle got en,busy,done,rdy,dir=%b exp=%b",
                     {en, busy, done, in_ready, dir}, {4'b0001, wd});
        end
    endtask

    task automatic test_fixed_words();
        run_frame(16'hA5C3, 1'b0);
        run_frame(16'hA5C3, 1'b1);
    endtask

    task automatic test_random_words();
        for (int n = 0; n < 6; n++) run_frame(MSB'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_back_to_back();
        int hs[$];
        int ndone = 0;
        logic [MSB-1:0] exp_w;
        in_valid = 1'b1; in_data = 16'h0001; in_dir = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (done === 1'b1) begin
                exp_w = (ndone == 0) ? 16'h0001 : 16'h8000;
                checks++;
                if (ds !== exp_w) begin
                    errors++;
                    $display("FAIL b2b_word%0d got=%h exp=%h", ndone, ds, exp_w);
                end
                ndone++;
            end
            if (hs.size() == 1 && cyc == hs[0] + 1) begin
                in_data = 16'h8000; in_dir = 1'b1;
            end
            if (hs.size() == 2 && cyc == hs[1] + 1) in_valid = 1'b0;
            if (in_valid && in_ready) hs.push_back(cyc);
            tick();
        end
        checks++;
        if (hs.size() != 2 || hs[1] - hs[0] != MSB + 2) begin
            errors++;
            $display("FAIL b2b_spacing handshakes=%0d gap=%0d exp=2 gap=%0d", hs.size(),
                     (hs.size() >= 2) ? hs[1] - hs[0] : -1, MSB + 2);
        end
        checks++;
        if (ndone != 2) begin
            errors++;
            $display("FAIL b2b_done_count got=%0d exp=2", ndone);
        end
    endtask

    task automatic test_rst_mid_frame();
        int stray = 0;
        in_data = 16'hFFFF; in_dir = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        checks++;
        if ({en, busy} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_pre got en,busy=%b exp=11", {en, busy});
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({en, d, dir, busy, done, in_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL rst_mid got en,d,dir,busy,done,rdy=%b exp=000001",
                     {en, d, dir, busy, done, in_ready});
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done !== 1'b0 || en !== 1'b0) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rst_mid_no_done got stray_cycles=%0d exp=0", stray);
        end
    endtask

    task automatic test_rst_with_valid();
        in_data = MSB'($urandom); in_dir = 1'b1; in_valid = 1'b1; rst = 1'b1;
        tick();
        checks++;
        if ({en, busy, in_ready, dir} !== 4'b0010) begin
            errors++;
            $display("FAIL rst_valid got en,busy,rdy,dir=%b exp=0010", {en, busy, in_ready, dir});
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        checks++;
        if ({en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_valid_next got en,busy=%b exp=00", {en, busy});
        end
    endtask

    initial begin
        test_reset();
        test_fixed_words();
        test_random_words();
        test_back_to_back();
        test_rst_mid_frame();
        test_rst_with_valid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
